// File: rtl/key_debounce_pkg.sv
// Shared definitions for the pushbutton conditioner: per-key FSM states and
// default timing constants for a 100 MHz system clock.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int unsigned DEF_NKEYS        = 5;
  localparam int unsigned DEF_TICK_DIV     = 100000;
  localparam int unsigned DEF_STABLE_TICKS = 20;
  localparam bit          DEF_REPEAT_EN    = 1'b1;
  localparam int unsigned DEF_REPEAT_DELAY = 500;
  localparam int unsigned DEF_REPEAT_RATE  = 100;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, debounce/auto-repeat FSM and registered
// level/press/repeat/release outputs, advanced by the shared sample tick.
module key_debounce_cell
  import key_debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter bit          REPEAT_EN    = DEF_REPEAT_EN,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_repeat,
  output logic key_release
);

  localparam int unsigned SW = $clog2(STABLE_TICKS) + 1;
  localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE)) + 1;

  logic          sync1_q, sync2_q;
  key_state_e    state_q, state_d;
  logic [SW-1:0] stab_q, stab_d, stab_inc;
  logic [RW-1:0] rpt_q, rpt_d, rpt_inc, rpt_target;
  logic          rpt_phase_q, rpt_phase_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rep_pulse_q, rep_pulse_d;
  logic          release_q, release_d;

  // rpt restarts from 0 after each repeat and the target switches from the
  // initial delay to the rate, so the counter never exceeds the larger of the two.
  always_comb begin
    state_d     = state_q;
    stab_d      = stab_q;
    rpt_d       = rpt_q;
    rpt_phase_d = rpt_phase_q;
    level_d     = level_q;
    press_d     = 1'b0;
    rep_pulse_d = 1'b0;
    release_d   = 1'b0;
    stab_inc    = stab_q + SW'(1);
    rpt_inc     = (rpt_q == '1) ? rpt_q : rpt_q + RW'(1);
    rpt_target  = rpt_phase_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);

    case (state_q)
      ST_IDLE: begin
        level_d = 1'b0;
        if (sync2_q) begin
          state_d = ST_PRESS_WAIT;
          stab_d  = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          stab_d = stab_inc;
          if (stab_inc == SW'(STABLE_TICKS)) begin
            state_d     = ST_HELD;
            press_d     = 1'b1;
            level_d     = 1'b1;
            rpt_d       = '0;
            rpt_phase_d = 1'b0;
          end
        end
      end
      ST_HELD: begin
        if (!sync2_q) begin
          state_d = ST_RELEASE_WAIT;
          stab_d  = '0;
        end else if (tick) begin
          rpt_d = rpt_inc;
          if (REPEAT_EN && (rpt_inc == rpt_target)) begin
            press_d     = 1'b1;
            rep_pulse_d = 1'b1;
            rpt_d       = '0;
            rpt_phase_d = 1'b1;
          end
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = ST_HELD;
        end else if (tick) begin
          stab_d = stab_inc;
          if (stab_inc == SW'(STABLE_TICKS)) begin
            state_d   = ST_IDLE;
            release_d = 1'b1;
            level_d   = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= ST_IDLE;
      stab_q      <= '0;
      rpt_q       <= '0;
      rpt_phase_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      rep_pulse_q <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      sync1_q     <= key_raw;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      stab_q      <= stab_d;
      rpt_q       <= rpt_d;
      rpt_phase_q <= rpt_phase_d;
      level_q     <= level_d;
      press_q     <= press_d;
      rep_pulse_q <= rep_pulse_d;
      release_q   <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_repeat  = rep_pulse_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// Pushbutton conditioner for the ALU board: shared sample-tick prescaler
// feeding one independent debounce cell per key.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned NKEYS        = DEF_NKEYS,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STABLE_TICKS = DEF_STABLE_TICKS,
  parameter bit          REPEAT_EN    = DEF_REPEAT_EN,
  parameter int unsigned REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_raw,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_repeat,
  output logic [NKEYS-1:0] key_release
);

  localparam int unsigned CW = $clog2(TICK_DIV) + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce_cell #(
      .STABLE_TICKS (STABLE_TICKS),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .key_raw     (key_raw[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_repeat  (key_repeat[i]),
      .key_release (key_release[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with a 4-cycle tick, 3-tick debounce and
// 5/2-tick auto-repeat; stimulus is aligned to the tick phase so timing is exact.
module tb_key_debounce;

  localparam int unsigned NK = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_raw = '0;
  logic [NK-1:0] key_level, key_press, key_repeat, key_release;

  key_debounce #(
    .NKEYS        (NK),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .REPEAT_EN    (1'b1),
    .REPEAT_DELAY (5),
    .REPEAT_RATE  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_raw     (key_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_repeat  (key_repeat),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  // Edges since reset release; ticks are sampled on edges where this becomes a multiple of 4.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int h0; int h1; bit bounce;
    int press0; int rep0; int rel0; int lvl0; int first0;
    int press1; int rel1; int lvl1; int first1;
  } vec_t;

  vec_t vecs[9];

  task automatic align();
    int n = 0;
    @(negedge clk);
    while ((cyc % 4 != 0) && (n < 8)) begin
      @(negedge clk);
      n++;
    end
  endtask

  function automatic logic [NK-1:0] drive(input vec_t v, input int j);
    logic r0, r1;
    r0 = v.bounce ? ((j < 30) && ((j / 3) % 2 == 0)) : (j < v.h0);
    r1 = (j < v.h1);
    return {r1, r0};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int w, p0, r0, l0, lv0, f0, p1, l1, lv1, f1, rnp;
    string tag;
    w = ((v.h0 > v.h1) ? v.h0 : v.h1);
    if (w < 30) w = 30;
    w = w + 50;
    p0 = 0; r0 = 0; l0 = 0; lv0 = 0; f0 = -1;
    p1 = 0; l1 = 0; lv1 = 0; f1 = -1; rnp = 0;
    align();
    key_raw = drive(v, 0);
    for (int k = 1; k <= w; k++) begin
      @(negedge clk);
      if (key_press[0])   begin p0++; if (f0 < 0) f0 = k; end
      if (key_press[1])   begin p1++; if (f1 < 0) f1 = k; end
      if (key_repeat[0])  r0++;
      if (key_release[0]) l0++;
      if (key_release[1]) l1++;
      if (key_level[0])   lv0++;
      if (key_level[1])   lv1++;
      if ((key_repeat & ~key_press) != '0) rnp++;
      if (key_repeat[1])  rnp++;
      key_raw = drive(v, k);
    end
    tag = $sformatf("vec%0d", idx);
    check({tag, " press0"},   p0,  v.press0);
    check({tag, " repeat0"},  r0,  v.rep0);
    check({tag, " release0"}, l0,  v.rel0);
    check({tag, " level0"},   lv0, v.lvl0);
    check({tag, " first0"},   f0,  v.first0);
    check({tag, " press1"},   p1,  v.press1);
    check({tag, " release1"}, l1,  v.rel1);
    check({tag, " level1"},   lv1, v.lvl1);
    check({tag, " first1"},   f1,  v.first1);
    check({tag, " rep_only"}, rnp, 0);
  endtask

  initial begin
    int pk[$];
    int exp_pk[4];
    int nrel, nlev, nrep, waitn, fpress, npress;

    vecs[0] = '{14,  0, 1'b0,  1,  0, 1,  16, 12,  0, 0,  0, -1};
    vecs[1] = '{ 0,  0, 1'b1,  0,  0, 0,   0, -1,  0, 0,  0, -1};
    vecs[2] = '{ 9,  0, 1'b0,  0,  0, 0,   0, -1,  0, 0,  0, -1};
    vecs[3] = '{10,  0, 1'b0,  1,  0, 1,  12, 12,  0, 0,  0, -1};
    vecs[4] = '{37,  0, 1'b0,  2,  1, 1,  40, 12,  0, 0,  0, -1};
    vecs[5] = '{38,  0, 1'b0,  3,  2, 1,  40, 12,  0, 0,  0, -1};
    vecs[6] = '{240, 0, 1'b0, 28, 27, 1, 240, 12,  0, 0,  0, -1};
    vecs[7] = '{14, 14, 1'b0,  1,  0, 1,  16, 12,  1, 1, 16, 12};
    vecs[8] = '{ 0, 20, 1'b0,  0,  0, 0,   0, -1,  1, 1, 20, 12};

    #23;
    check("reset_outputs", int'({key_level, key_press, key_repeat, key_release}), 0);
    #4 rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Release glitch of 5 cycles while held: rpt freezes, schedule resumes.
    exp_pk = '{12, 32, 48, 56};
    nrel = 0; nlev = 0; nrep = 0;
    align();
    key_raw = 2'b01;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (key_press[0])   pk.push_back(k);
      if (key_repeat[0])  nrep++;
      if (key_release[0]) nrel++;
      if (key_level[0])   nlev++;
      key_raw = ((k >= 33) && (k <= 37)) ? 2'b00 : 2'b01;
    end
    check("glitch npress", pk.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("glitch press_k%0d", i), (i < pk.size()) ? pk[i] : -1, exp_pk[i]);
    check("glitch repeats", nrep, 3);
    check("glitch release", nrel, 0);
    check("glitch level", nlev, 49);
    key_raw = 2'b00;
    waitn = 0;
    nrel = 0;
    while (key_level[0] && (waitn < 40)) begin
      @(negedge clk);
      if (key_release[0]) nrel++;
      waitn++;
    end
    check("glitch final_release", nrel, 1);
    check("glitch final_level", int'(key_level[0]), 0);

    // Reset while held: immediate clear, no release afterwards, fresh press.
    repeat (20) @(negedge clk);
    align();
    key_raw = 2'b01;
    repeat (20) @(negedge clk);
    check("pre_rst level", int'(key_level[0]), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async outputs", int'({key_level, key_press, key_repeat, key_release}), 0);
    @(negedge clk);
    @(negedge clk);
    check("rst_held outputs", int'({key_level, key_press, key_repeat, key_release}), 0);
    #2 rst = 1'b0;
    fpress = -1; npress = 0; nrel = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (key_press[0]) begin npress++; if (fpress < 0) fpress = cyc; end
      if (key_release != '0) nrel++;
    end
    check("post_rst release", nrel, 0);
    check("post_rst npress", npress, 1);
    check("post_rst press_cyc", fpress, 12);
    check("post_rst level", int'(key_level[0]), 1);
    key_raw = 2'b00;
    repeat (30) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
